imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning immediate output width; legal values 32 and 64 only.
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of register stages; legal values 1..4.
REQ-003 SHALL have parameter SHIFT_BRANCH, default 1, meaning 1 = B and CB offsets are shifted left 2, 0 = raw offsets.
REQ-004 SHALL have port clock  input  1  single clock for the block.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous pipeline clear.
REQ-007 SHALL have port in_valid  input  1  instruction present.
REQ-008 SHALL have port in_ready  output  1  block accepts the instruction this cycle.
REQ-009 SHALL have port instruction  input  32  LEGv8 instruction word.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port imm_out  output  DATA_W  extended immediate.
REQ-013 SHALL have port fmt_out  output  3  format code: 0 none, 1 D, 2 I, 3 B, 4 CB, 5 IW.
REQ-014 SHALL have port illegal  output  1  no format matched.
REQ-015 SHALL have port illegal_cnt  output  16  saturating count of illegal words accepted.

Function
REQ-016 Decoding SHALL use first match in this order:
- instr[31:21] = 11111000010 or 11111000000 -> D: sign-extend instr[20:12].
- instr[31:22] = 1001000100 or 1101000100 -> I: zero-extend instr[21:10].
- instr[31:26] = 000101 or 100101 -> B: sign-extend instr[25:0].
- instr[31:24] = 10110100, 10110101 or 01010100 -> CB: sign-extend instr[23:5].
- instr[31:23] = 110100101 or 111100101 -> IW: zero-extend instr[20:5], shifted left by 16*instr[22:21].
REQ-017 If SHIFT_BRANCH=1, B and CB results SHALL be {sign-extended field, 2'b00}, truncated to DATA_W.
REQ-018 If DATA_W=32 and an IW word has instr[22]=1, the word SHALL be treated as illegal.
REQ-019 An illegal word SHALL give imm_out=0, fmt_out=0, illegal=1; it SHALL still flow through the pipeline as a normal transfer.
REQ-020 Decode SHALL be combinational into stage 1; stages 1..DEPTH SHALL each hold valid, imm, fmt and illegal.
REQ-021 A stage SHALL load when it is empty or when its contents advance in the same cycle.
REQ-022 in_ready SHALL equal !flush && (stage 1 empty || stage 1 advances); a transfer occurs on in_valid && in_ready.
REQ-023 With out_ready held high, latency SHALL be exactly DEPTH cycles and throughput 1 word per cycle.
REQ-024 out_valid, imm_out, fmt_out and illegal SHALL come from stage DEPTH and SHALL stay stable while out_valid && !out_ready.
REQ-025 With out_ready low, the block SHALL accept up to DEPTH words, then hold in_ready low, with no loss, duplication or reordering.
REQ-026 flush SHALL clear every stage valid bit at the next edge and SHALL discard any same-cycle input.
REQ-027 Data registers MAY retain stale values after a flush; illegal_cnt SHALL NOT change on flush.
REQ-028 illegal_cnt SHALL increment on each accepted illegal word, SHALL saturate at 0xFFFF, and SHALL NOT be affected by flush.

Reset
REQ-029 When reset is asserted, asynchronously: all valid bits = 0, imm_out = 0, fmt_out = 0, illegal = 0, illegal_cnt = 0.
REQ-030 While reset is high, in_ready SHALL be 0; in-flight words SHALL be dropped when reset asserts mid-operation.
REQ-031 The first transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-032 Sign-extended load offset (DEPTH=2, DATA_W=64): 0xF85FF000 (LDUR, imm9 = -1) -> two cycles later imm_out = 0xFFFFFFFFFFFFFFFF, fmt_out = 1.
REQ-033 Branch offset shift: 0x17FFFFFE (B, imm26 = -2), SHIFT_BRANCH=1 -> imm_out = 0xFFFFFFFFFFFFFFF8, fmt_out = 3; with SHIFT_BRANCH=0 -> 0xFFFFFFFFFFFFFFFE.
REQ-034 Wide-immediate shift: 0xD2C24680 (MOVZ, hw=2, imm16=0x1234) -> imm_out = 0x0000123400000000, fmt_out = 5; same word with DATA_W=32 -> illegal = 1, imm_out = 0.
REQ-035 Backpressure: stream 8 words, out_ready low on cycles 3-5 -> in_ready low after DEPTH words buffered; all 8 words emerge in order, outputs stable while stalled.
REQ-036 Illegal words and flush: 0x00000000 accepted -> illegal = 1, illegal_cnt = 1; flush with 2 words in flight -> out_valid = 0 the next cycle, illegal_cnt unchanged.
REQ-037 Reset mid-stream: async reset during cycle 2 of a stream -> all outputs zero immediately; first word after release emerges DEPTH cycles after acceptance.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - LEGv8 immediate extractor feeding an elastic register pipeline
module imm_extend_pipe #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 2,
    parameter int SHIFT_BRANCH = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic [2:0]        fmt_out,
    output logic              illegal,
    output logic [15:0]       illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_D    = 3'd1;
    localparam logic [2:0] FMT_I    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_CB   = 3'd4;
    localparam logic [2:0] FMT_IW   = 3'd5;

    logic [63:0]       w_imm64;
    logic [63:0]       w_iw;
    logic [2:0]        w_fmt;
    logic              w_illegal;
    logic              w_accept;
    logic [DEPTH-1:0]  w_load;
    logic              w_unused;

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_imm [DEPTH];
    logic [2:0]        r_fmt [DEPTH];
    logic [DEPTH-1:0]  r_ill;
    logic [15:0]       r_cnt;

    assign w_unused = ^instruction[4:0];
    assign w_iw     = {48'b0, instruction[20:5]} << {instruction[22:21], 4'b0000};

    always_comb begin
        w_imm64   = '0;
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        if (instruction[31:21] == 11'h7C2 || instruction[31:21] == 11'h7C0) begin
            w_imm64 = {{55{instruction[20]}}, instruction[20:12]};
            w_fmt   = FMT_D;
        end else if (instruction[31:22] == 10'h244 || instruction[31:22] == 10'h344) begin
            w_imm64 = {52'b0, instruction[21:10]};
            w_fmt   = FMT_I;
        end else if (instruction[31:26] == 6'h05 || instruction[31:26] == 6'h25) begin
            if (SHIFT_BRANCH != 0) w_imm64 = {{36{instruction[25]}}, instruction[25:0], 2'b00};
            else                   w_imm64 = {{38{instruction[25]}}, instruction[25:0]};
            w_fmt = FMT_B;
        end else if (instruction[31:24] == 8'hB4 || instruction[31:24] == 8'hB5 ||
                     instruction[31:24] == 8'h54) begin
            if (SHIFT_BRANCH != 0) w_imm64 = {{43{instruction[23]}}, instruction[23:5], 2'b00};
            else                   w_imm64 = {{45{instruction[23]}}, instruction[23:5]};
            w_fmt = FMT_CB;
        end else if (instruction[31:23] == 9'h1A5 || instruction[31:23] == 9'h1E5) begin
            // A 32-bit result cannot hold imm16 placed at bit 32 or 48.
            if (DATA_W == 32 && instruction[22]) begin
                w_illegal = 1'b1;
            end else begin
                w_imm64 = w_iw;
                w_fmt   = FMT_IW;
            end
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Stage k can load when it or any later stage is empty, or the output drains.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_load[k] = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!r_valid[j]) w_load[k] = 1'b1;
            end
        end
    end

    assign in_ready = !reset && !flush && w_load[0];
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_ill   <= '0;
            r_cnt   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_imm[k] <= '0;
                r_fmt[k] <= FMT_NONE;
            end
        end else begin
            if (flush) begin
                r_valid <= '0;
            end else begin
                if (w_load[0]) r_valid[0] <= w_accept;
                for (int k = 1; k < DEPTH; k++) begin
                    if (w_load[k]) r_valid[k] <= r_valid[k-1];
                end
            end
            if (w_load[0]) begin
                r_imm[0] <= w_illegal ? '0 : w_imm64[DATA_W-1:0];
                r_fmt[0] <= w_fmt;
                r_ill[0] <= w_illegal;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_imm[k] <= r_imm[k-1];
                    r_fmt[k] <= r_fmt[k-1];
                    r_ill[k] <= r_ill[k-1];
                end
            end
            if (w_accept && w_illegal && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign out_valid   = r_valid[DEPTH-1];
    assign imm_out     = r_imm[DEPTH-1];
    assign fmt_out     = r_fmt[DEPTH-1];
    assign illegal     = r_ill[DEPTH-1];
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - bench for imm_extend_pipe (64-bit shifted and 32-bit raw instances)
module tb_imm_extend_pipe;

    localparam int D = 2;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        dec_t a;
        dec_t b;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm_a;
        logic [2:0]  fmt_a;
        logic        ill_a;
        logic [31:0] imm_b;
        logic [2:0]  fmt_b;
        logic        ill_b;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, ill_a;
    logic [63:0] imm_a;
    logic [2:0]  fmt_a;
    logic [15:0] cnt_a;
    logic        in_ready_b, out_valid_b, ill_b;
    logic [31:0] imm_b;
    logic [2:0]  fmt_b;
    logic [15:0] cnt_b;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   sb_en = 1'b0;
    exp_t q[$];
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    bit   prev_stall = 1'b0;
    logic [63:0] prev_imm_a;
    logic [2:0]  prev_fmt_a;
    logic        prev_ill_a;
    logic [31:0] prev_imm_b;

    imm_extend_pipe #(.DATA_W(64), .DEPTH(D), .SHIFT_BRANCH(1)) dut_a (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .instruction(instruction), .out_valid(out_valid_a), .out_ready(out_ready),
        .imm_out(imm_a), .fmt_out(fmt_a), .illegal(ill_a), .illegal_cnt(cnt_a)
    );

    imm_extend_pipe #(.DATA_W(32), .DEPTH(D), .SHIFT_BRANCH(0)) dut_b (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instruction(instruction), .out_valid(out_valid_b), .out_ready(out_ready),
        .imm_out(imm_b), .fmt_out(fmt_b), .illegal(ill_b), .illegal_cnt(cnt_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode: field values taken as integers, signed by range test, scaled by multiplication.
    function automatic dec_t model(input logic [31:0] w, input bit narrow, input bit sb);
        dec_t   r;
        longint v;
        int     hw;
        r.imm = '0; r.fmt = 3'd0; r.ill = 1'b0; v = 0;
        if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
            v = longint'(w[20:12]);
            if (v >= 256) v = v - 512;
            r.fmt = 3'd1;
        end else if (w[31:22] == 10'h244 || w[31:22] == 10'h344) begin
            v = longint'(w[21:10]);
            r.fmt = 3'd2;
        end else if (w[31:26] == 6'h05 || w[31:26] == 6'h25) begin
            v = longint'(w[25:0]);
            if (v >= 33554432) v = v - 67108864;
            if (sb) v = v * 4;
            r.fmt = 3'd3;
        end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5 || w[31:24] == 8'h54) begin
            v = longint'(w[23:5]);
            if (v >= 262144) v = v - 524288;
            if (sb) v = v * 4;
            r.fmt = 3'd4;
        end else if (w[31:23] == 9'h1A5 || w[31:23] == 9'h1E5) begin
            hw = int'(w[22:21]);
            if (narrow && hw >= 2) begin
                r.ill = 1'b1;
            end else begin
                v = longint'(w[20:5]);
                for (int i = 0; i < hw; i++) v = v * 65536;
                r.fmt = 3'd5;
            end
        end else begin
            r.ill = 1'b1;
        end
        r.imm = r.ill ? 64'd0 : (narrow ? (64'(v) & 64'hFFFF_FFFF) : 64'(v));
        return r;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 2);
        case ($urandom_range(0, 7))
            0: w[31:21] = ($urandom % 2 != 0) ? 11'h7C2 : 11'h7C0;
            1: w[31:22] = ($urandom % 2 != 0) ? 10'h244 : 10'h344;
            2: w[31:26] = ($urandom % 2 != 0) ? 6'h05 : 6'h25;
            3: w[31:24] = (sel == 0) ? 8'hB4 : ((sel == 1) ? 8'hB5 : 8'h54);
            4: w[31:23] = ($urandom % 2 != 0) ? 9'h1A5 : 9'h1E5;
            5: w = '0;
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard: accepted words queue in order; pipeline holds at most D of them.
    always @(negedge clock) begin
        if (sb_en) begin
            exp_t e;
            chk("in_ready_a", in_ready_a, !flush && (q.size() < D || out_ready));
            chk("in_ready_b", in_ready_b, !flush && (q.size() < D || out_ready));
            chk("cnt_a", cnt_a, 64'(exp_cnt_a));
            chk("cnt_b", cnt_b, 64'(exp_cnt_b));
            chk("out_valid_b", out_valid_b, out_valid_a);
            if (prev_stall) begin
                chk("stall_valid", out_valid_a, 1);
                chk("stall_imm_a", imm_a, prev_imm_a);
                chk("stall_fmt_a", fmt_a, prev_fmt_a);
                chk("stall_ill_a", ill_a, prev_ill_a);
                chk("stall_imm_b", imm_b, prev_imm_b);
            end
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    chk("sb_imm_a", imm_a, e.a.imm);
                    chk("sb_fmt_a", fmt_a, e.a.fmt);
                    chk("sb_ill_a", ill_a, e.a.ill);
                    chk("sb_imm_b", imm_b, e.b.imm);
                    chk("sb_fmt_b", fmt_b, e.b.fmt);
                    chk("sb_ill_b", ill_b, e.b.ill);
                end
            end
            prev_stall = out_valid_a && !out_ready;
            prev_imm_a = imm_a; prev_fmt_a = fmt_a; prev_ill_a = ill_a; prev_imm_b = imm_b;
            if (flush) begin
                q.delete();
                prev_stall = 1'b0;
            end else if (in_valid && in_ready_a) begin
                e.a = model(instruction, 1'b0, 1'b1);
                e.b = model(instruction, 1'b1, 1'b0);
                q.push_back(e);
                if (e.a.ill && exp_cnt_a < 65535) exp_cnt_a++;
                if (e.b.ill && exp_cnt_b < 65535) exp_cnt_b++;
            end
        end
    end

    task automatic apply_one(input vec_t v);
        @(posedge clock); #1;
        in_valid = 1'b1; instruction = v.instr; out_ready = 1'b1;
        @(negedge clock);
        chk("vec_rdy", in_ready_a, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("vec_lat_early", out_valid_a, 0);
        @(posedge clock);
        @(negedge clock);
        chk("vec_valid", out_valid_a, 1);
        chk("vec_imm_a", imm_a, v.imm_a);
        chk("vec_fmt_a", fmt_a, v.fmt_a);
        chk("vec_ill_a", ill_a, v.ill_a);
        chk("vec_imm_b", imm_b, v.imm_b);
        chk("vec_fmt_b", fmt_b, v.fmt_b);
        chk("vec_ill_b", ill_b, v.ill_b);
    endtask

    task automatic clear_model();
        q.delete();
        exp_cnt_a  = 0;
        exp_cnt_b  = 0;
        prev_stall = 1'b0;
    endtask

    initial begin
        vec_t        tbl[10];
        logic [31:0] words[8];
        int          idx;
        int          snap_a;

        tbl[0] = '{32'h0000_0000, 64'h0, 3'd0, 1'b1, 32'h0, 3'd0, 1'b1};
        tbl[1] = '{32'hF85F_F000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF, 3'd1, 1'b0};
        tbl[2] = '{32'h17FF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0, 32'hFFFF_FFFE, 3'd3, 1'b0};
        tbl[3] = '{32'hD2C2_4680, 64'h0000_1234_0000_0000, 3'd5, 1'b0, 32'h0, 3'd0, 1'b1};
        tbl[4] = '{32'h9100_0400, 64'h1, 3'd2, 1'b0, 32'h1, 3'd2, 1'b0};
        tbl[5] = '{32'hB4FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0, 32'hFFFF_FFFF, 3'd4, 1'b0};
        tbl[6] = '{32'hF280_0020, 64'h1, 3'd5, 1'b0, 32'h1, 3'd5, 1'b0};
        tbl[7] = '{32'h5400_0040, 64'h8, 3'd4, 1'b0, 32'h2, 3'd4, 1'b0};
        tbl[8] = '{32'hF800_0000, 64'h0, 3'd1, 1'b0, 32'h0, 3'd1, 1'b0};
        tbl[9] = '{32'h9400_0001, 64'h4, 3'd3, 1'b0, 32'h1, 3'd3, 1'b0};

        #1 reset = 1'b1;
        #1;
        chk("rst_valid", out_valid_a, 0);
        chk("rst_imm", imm_a, 0);
        chk("rst_fmt", fmt_a, 0);
        chk("rst_ill", ill_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_in_ready", in_ready_a, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        #1 clear_model(); sb_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_one(tbl[i]);
            if (i == 0) chk("first_illegal_cnt", cnt_a, 1);
        end
        @(posedge clock); @(negedge clock);

        // Flush with two words in flight; the illegal word offered during flush must be dropped.
        @(posedge clock); #1 out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hF85F_F000;
        @(posedge clock); #1 instruction = 32'h9100_0400;
        @(posedge clock); #1 snap_a = exp_cnt_a; out_ready = 1'b1; flush = 1'b1; instruction = 32'h0;
        @(negedge clock);
        chk("flush_in_ready", in_ready_a, 0);
        @(posedge clock); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("flush_out_valid_a", out_valid_a, 0);
        chk("flush_out_valid_b", out_valid_b, 0);
        chk("flush_cnt", cnt_a, 64'(snap_a));

        // Backpressure: 8 words, consumer stalls on cycles 3..5.
        for (int i = 0; i < 8; i++) words[i] = gen();
        idx = 0; n_out = 0;
        for (int c = 0; c < 60 && n_out < 8; c++) begin
            @(posedge clock); #1;
            out_ready   = !(c >= 3 && c <= 5);
            in_valid    = idx < 8;
            instruction = (idx < 8) ? words[idx] : 32'h0;
            @(negedge clock);
            if (c == 4) chk("bp_in_ready_low", in_ready_a, 0);
            if (in_valid && in_ready_a) idx++;
        end
        @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("bp_all_out", n_out, 8);

        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 3) != 0;
            flush       = ($urandom % 40) == 0;
            instruction = gen();
        end
        @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < 10 && q.size() != 0; c++) @(negedge clock);
        @(negedge clock);
        chk("drain_empty", q.size(), 0);

        // Asynchronous reset in the second cycle of a stream.
        @(posedge clock); #1 in_valid = 1'b1; instruction = 32'hF85F_F000;
        @(posedge clock); #1 instruction = 32'h9100_0400;
        #2 reset = 1'b1; sb_en = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_a, 0);
        chk("mid_rst_imm", imm_a, 0);
        chk("mid_rst_fmt", fmt_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);
        chk("mid_rst_in_ready", in_ready_a, 0);
        chk("mid_rst_valid_b", out_valid_b, 0);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1 clear_model(); sb_en = 1'b1;
        apply_one(tbl[2]);
        @(posedge clock); @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
